// File: rtl/ms_digit_counter.sv
// ms_digit_counter: multi-digit up/down counter with per-digit radix rollover, enable prescaler,
// parallel load (clamped) and carry/borrow strobes. Define MS_DIGIT_COUNTER_SAT_EN to saturate instead of wrap.
module ms_digit_counter #(
    parameter int DIGITS     = 3,
    parameter int RADIX      = 10,
    parameter int DIGIT_BITS = 4,
    parameter int PRESCALE   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         up,
    input  logic                         load,
    input  logic [DIGITS*DIGIT_BITS-1:0] din,
    output logic [DIGITS*DIGIT_BITS-1:0] q,
    output logic                         tick,
    output logic                         co,
    output logic                         bo,
    output logic                         zero,
    output logic                         max
);
    localparam int                    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]         PSC_LAST = PW'(PRESCALE - 1);
    localparam logic [DIGIT_BITS-1:0] DIG_MAX  = DIGIT_BITS'(RADIX - 1);

    logic [PW-1:0]                psc_q, psc_d;
    logic [DIGITS*DIGIT_BITS-1:0] cnt_q, cnt_d;
    logic [DIGITS*DIGIT_BITS-1:0] step_val, load_val;
    logic [DIGIT_BITS-1:0]        dig_c;
    logic                         carry_c;
    logic                         hold_sat;

    function automatic logic [DIGIT_BITS-1:0] clamp_digit(input logic [DIGIT_BITS-1:0] d);
        if (d > DIG_MAX) return DIG_MAX;
        return d;
    endfunction

    always_comb begin
        zero = 1'b1;
        max  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q[i*DIGIT_BITS +: DIGIT_BITS] != '0)      zero = 1'b0;
            if (cnt_q[i*DIGIT_BITS +: DIGIT_BITS] != DIG_MAX) max  = 1'b0;
        end
    end

    assign tick = en & ~load & (psc_q == PSC_LAST);
    assign co   = tick & up & max;
    assign bo   = tick & ~up & zero;
    assign q    = cnt_q;

`ifdef MS_DIGIT_COUNTER_SAT_EN
    assign hold_sat = (up & max) | (~up & zero);
`else
    assign hold_sat = 1'b0;
`endif

    // Single-cycle ripple: the carry/borrow chain walks from digit 0 upward.
    always_comb begin
        step_val = cnt_q;
        load_val = '0;
        carry_c  = 1'b1;
        dig_c    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_val[i*DIGIT_BITS +: DIGIT_BITS] = clamp_digit(din[i*DIGIT_BITS +: DIGIT_BITS]);
            dig_c = cnt_q[i*DIGIT_BITS +: DIGIT_BITS];
            if (carry_c) begin
                if (up) begin
                    if (dig_c == DIG_MAX) begin
                        dig_c = '0;
                    end else begin
                        dig_c   = dig_c + 1'b1;
                        carry_c = 1'b0;
                    end
                end else begin
                    if (dig_c == '0) begin
                        dig_c = DIG_MAX;
                    end else begin
                        dig_c   = dig_c - 1'b1;
                        carry_c = 1'b0;
                    end
                end
            end
            step_val[i*DIGIT_BITS +: DIGIT_BITS] = dig_c;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        psc_d = psc_q;
        if (load) begin
            cnt_d = load_val;
            psc_d = '0;
        end else begin
            if (en) psc_d = tick ? '0 : psc_q + 1'b1;
            if (tick && !hold_sat) cnt_d = step_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            psc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            psc_q <= psc_d;
        end
    end
endmodule

// File: tb/tb_ms_digit_counter.sv
// Scoreboard bench for ms_digit_counter: PRESCALE=1 and PRESCALE=4 instances share stimulus,
// each checked against an integer-valued reference model.
module tb_ms_digit_counter;
    localparam int W  = 12;
    localparam int NV = 1000;

    logic         clk = 1'b0;
    logic         rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
    logic [W-1:0] din = '0;

    logic [W-1:0] q_a, q_b;
    logic tick_a, co_a, bo_a, zero_a, max_a;
    logic tick_b, co_b, bo_b, zero_b, max_b;

    always #5 clk = ~clk;

    ms_digit_counter #(.DIGITS(3), .RADIX(10), .DIGIT_BITS(4), .PRESCALE(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .q(q_a), .tick(tick_a), .co(co_a), .bo(bo_a), .zero(zero_a), .max(max_a));

    ms_digit_counter #(.DIGITS(3), .RADIX(10), .DIGIT_BITS(4), .PRESCALE(4)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .q(q_b), .tick(tick_b), .co(co_b), .bo(bo_b), .zero(zero_b), .max(max_b));

    typedef struct packed {
        logic [W-1:0] q;
        logic         tick;
        logic         co;
        logic         bo;
        logic         zero;
        logic         mx;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int checks   = 0;
    int failures = 0;
    int mv[2]    = '{0, 0};
    int mp[2]    = '{0, 0};
    int ps[2]    = '{1, 4};

`ifdef MS_DIGIT_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    function automatic logic [W-1:0] to_digits(input int v);
        logic [W-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int from_din(input logic [W-1:0] d);
        int v, p, dg;
        v = 0;
        p = 1;
        for (int i = 0; i < 3; i++) begin
            dg = int'(d[i*4 +: 4]);
            if (dg > 9) dg = 9;
            v = v + dg * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, ex, $time);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit u, input bit l,
                         input logic [W-1:0] d, input bit push);
        exp_t x;
        bit   t;
        @(posedge clk);
        #1;
        rst = r; en = e; up = u; load = l; din = d;
        for (int k = 0; k < 2; k++) begin
            t      = e && !l && (mp[k] == ps[k] - 1);
            x.q    = to_digits(mv[k]);
            x.tick = t;
            x.co   = t && u && (mv[k] == NV - 1);
            x.bo   = t && !u && (mv[k] == 0);
            x.zero = (mv[k] == 0);
            x.mx   = (mv[k] == NV - 1);
            if (push) begin
                if (k == 0) qa.push_back(x);
                else        qb.push_back(x);
            end
            if (r) begin
                mv[k] = 0;
                mp[k] = 0;
            end else if (l) begin
                mv[k] = from_din(d);
                mp[k] = 0;
            end else begin
                if (e) mp[k] = t ? 0 : mp[k] + 1;
                if (t) begin
                    if (u) mv[k] = (mv[k] == NV - 1) ? (SAT ? NV - 1 : 0) : mv[k] + 1;
                    else   mv[k] = (mv[k] == 0) ? (SAT ? 0 : NV - 1) : mv[k] - 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            cmp("a_q",    q_a,         ea.q);
            cmp("a_tick", W'(tick_a),  W'(ea.tick));
            cmp("a_co",   W'(co_a),    W'(ea.co));
            cmp("a_bo",   W'(bo_a),    W'(ea.bo));
            cmp("a_zero", W'(zero_a),  W'(ea.zero));
            cmp("a_max",  W'(max_a),   W'(ea.mx));
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            cmp("b_q",    q_b,         eb.q);
            cmp("b_tick", W'(tick_b),  W'(eb.tick));
            cmp("b_co",   W'(co_b),    W'(eb.co));
            cmp("b_bo",   W'(bo_b),    W'(eb.bo));
            cmp("b_zero", W'(zero_b),  W'(eb.zero));
            cmp("b_max",  W'(max_b),   W'(eb.mx));
        end
    end

    initial begin
        drive(1, 0, 0, 0, '0, 0);
        drive(1, 0, 0, 0, '0, 1);
        repeat (12) drive(0, 1, 1, 0, '0, 1);
        drive(1, 0, 1, 0, '0, 1);
        // Carry wrap from 999
        drive(0, 0, 1, 1, 12'h999, 1);
        repeat (6) drive(0, 1, 1, 0, '0, 1);
        // Borrow from 100 and from 000
        drive(0, 0, 0, 1, 12'h100, 1);
        repeat (5) drive(0, 1, 0, 0, '0, 1);
        drive(0, 0, 0, 1, 12'h000, 1);
        repeat (5) drive(0, 1, 0, 0, '0, 1);
        // Prescaler with enable gap mid-period
        drive(1, 0, 1, 0, '0, 1);
        repeat (2) drive(0, 1, 1, 0, '0, 1);
        repeat (2) drive(0, 0, 1, 0, '0, 1);
        repeat (8) drive(0, 1, 1, 0, '0, 1);
        // Load priority over a due tick, clamp, and rst over load
        drive(1, 0, 1, 0, '0, 1);
        repeat (3) drive(0, 1, 1, 0, '0, 1);
        drive(0, 1, 1, 1, 12'hF5A, 1);
        drive(0, 0, 1, 0, '0, 1);
        drive(1, 1, 1, 1, 12'h123, 1);
        drive(0, 0, 1, 0, '0, 1);
        // Direction change mid-period
        drive(0, 0, 1, 1, 12'h005, 1);
        repeat (2) drive(0, 1, 1, 0, '0, 1);
        repeat (4) drive(0, 1, 0, 0, '0, 1);
        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1, ($urandom_range(0, 15) == 0),
                  W'($urandom), 1);
        end
        for (int n = 0; n < 4 && (qa.size() > 0 || qb.size() > 0); n++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d/%0d required=0/0", qa.size(), qb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
